counter_access_arbiter: RTL and testbench



---
 rtl/counter_access_arbiter.sv | 160 ++++++++++++++++
 tb/tb_counter_access_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_access_arbiter.sv
// Round-robin arbiter sharing one counter core between requesters.
// Sequences single register accesses and keeps a sticky irq flag.
module counter_access_arbiter #(
  parameter  int NUM_REQ = 2,
  localparam int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     we,
  input  logic [2*NUM_REQ-1:0]   addr,
  input  logic [32*NUM_REQ-1:0]  wdata,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     rvalid,
  output logic [31:0]            rdata,
  output logic                   irq,
  output logic [31:0]            counterIn,
  output logic                   counterEnIn,
  output logic                   counterDirIn,
  output logic                   counterWe,
  output logic                   counterRe,
  output logic                   counterConfigWe,
  output logic                   counterConfigRe,
  output logic                   counterStatusRe,
  input  logic [31:0]            counterOut,
  input  logic                   counterEnOut,
  input  logic                   counterDirOut,
  input  logic                   counterLT1000Out,
  input  logic                   counterIrq
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] own_q, own_d;
  logic             we_q, we_d;
  logic [1:0]       addr_q, addr_d;
  logic [31:0]      wd_q, wd_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             irq_q, irq_d;

  logic [PTR_W-1:0] win;
  logic             found;
  logic [31:0]      rd_val;
  logic             irq_clr;

  // Round-robin scan starting at the pointer, wrapping modulo NUM_REQ
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req[(int'(ptr_q) + k) % NUM_REQ]) begin
        found = 1'b1;
        win   = PTR_W'((int'(ptr_q) + k) % NUM_REQ);
      end
    end
  end

  // Register-map read mux from the latched address
  always_comb begin
    rd_val = '0;
    unique case (addr_q)
      2'd0:    rd_val = counterOut;
      2'd1:    rd_val = {30'b0, counterDirOut, counterEnOut};
      2'd2:    rd_val = {31'b0, counterLT1000Out};
      default: rd_val = {31'b0, irq_q};
    endcase
  end

  // Next-state logic for sequencer, latches, pointer and irq flag
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    rdata_d = rdata_q;
    irq_clr = (state_q == ACCESS) && we_q
              && (addr_q == 2'd3) && wd_q[0];
    irq_d   = counterIrq | (irq_q & ~irq_clr);
    unique case (state_q)
      IDLE: begin
        if (found) begin
          own_d   = win;
          we_d    = we[win];
          addr_d  = addr[2*win +: 2];
          wd_d    = wdata[32*win +: 32];
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        rdata_d = we_q ? 32'h0 : rd_val;
        ptr_d   = PTR_W'((int'(own_q) + 1) % NUM_REQ);
        state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      own_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wd_q    <= '0;
      rdata_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      rdata_q <= rdata_d;
      irq_q   <= irq_d;
    end
  end

  // Handshake pulses and core strobes, decoded from registered state only
  always_comb begin
    gnt             = '0;
    rvalid          = '0;
    counterWe       = 1'b0;
    counterRe       = 1'b0;
    counterConfigWe = 1'b0;
    counterConfigRe = 1'b0;
    counterStatusRe = 1'b0;
    if (state_q == ACCESS) begin
      gnt[own_q] = 1'b1;
      unique case ({we_q, addr_q})
        3'b100:  counterWe       = 1'b1;
        3'b000:  counterRe       = 1'b1;
        3'b101:  counterConfigWe = 1'b1;
        3'b001:  counterConfigRe = 1'b1;
        3'b010:  counterStatusRe = 1'b1;
        default: ;
      endcase
    end
    if (state_q == RESP) begin
      rvalid[own_q] = 1'b1;
    end
  end

  assign rdata        = rdata_q;
  assign irq          = irq_q;
  assign counterIn    = wd_q;
  assign counterEnIn  = wd_q[0];
  assign counterDirIn = wd_q[1];

endmodule

// File: tb/tb_counter_access_arbiter.sv
// Bench for counter_access_arbiter: core stub, transaction model,
// per-cycle compare and directed register-map scenarios.
module tb_counter_access_arbiter;

  localparam int N = 2;

  logic            clk;
  logic            reset;
  logic [N-1:0]    req;
  logic [N-1:0]    we;
  logic [2*N-1:0]  addr;
  logic [32*N-1:0] wdata;
  logic [N-1:0]    gnt;
  logic [N-1:0]    rvalid;
  logic [31:0]     rdata;
  logic            irq;
  logic [31:0]     counterIn;
  logic            counterEnIn;
  logic            counterDirIn;
  logic            counterWe;
  logic            counterRe;
  logic            counterConfigWe;
  logic            counterConfigRe;
  logic            counterStatusRe;
  logic [31:0]     counterOut;
  logic            counterEnOut;
  logic            counterDirOut;
  logic            counterLT1000Out;
  logic            counterIrq;

  counter_access_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we),
    .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid),
    .rdata(rdata), .irq(irq), .counterIn(counterIn),
    .counterEnIn(counterEnIn), .counterDirIn(counterDirIn),
    .counterWe(counterWe), .counterRe(counterRe),
    .counterConfigWe(counterConfigWe),
    .counterConfigRe(counterConfigRe),
    .counterStatusRe(counterStatusRe),
    .counterOut(counterOut), .counterEnOut(counterEnOut),
    .counterDirOut(counterDirOut),
    .counterLT1000Out(counterLT1000Out),
    .counterIrq(counterIrq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
               $time);
    end
  endtask

  // Core stub: plain registers loaded by the write strobes
  logic [31:0] c_cnt = '0;
  logic        c_en  = 1'b0;
  logic        c_dir = 1'b0;
  always @(posedge clk) begin
    if (counterWe === 1'b1) c_cnt <= counterIn;
    if (counterConfigWe === 1'b1) begin
      c_en  <= counterEnIn;
      c_dir <= counterDirIn;
    end
  end
  assign counterOut       = c_cnt;
  assign counterEnOut     = c_en;
  assign counterDirOut    = c_dir;
  assign counterLT1000Out = (c_cnt < 32'd1000);

  // Transaction model: phase counts cycles since the grant decision
  int          m_phase = 0;
  int          m_ptr   = 0;
  int          m_own   = 0;
  bit          m_we    = 1'b0;
  logic [1:0]  m_addr  = '0;
  logic [31:0] m_wd    = '0;
  logic [31:0] m_rdata = '0;
  bit          m_irq   = 1'b0;
  bit          started = 1'b0;
  int          pick;

  function automatic logic [31:0] reg_read(input logic [1:0] a,
                                           input bit irqv);
    case (a)
      2'd0:    return c_cnt;
      2'd1:    return {30'b0, c_dir, c_en};
      2'd2:    return (c_cnt < 32'd1000) ? 32'd1 : 32'd0;
      default: return {31'b0, irqv};
    endcase
  endfunction

  // Strobe vector {We,Re,CfgWe,CfgRe,StRe} expected for an access kind
  function automatic logic [4:0] exp_stb(input int ph, input bit w,
                                         input logic [1:0] a);
    if (ph != 1) return 5'b0;
    case ({w, a})
      3'b100:  return 5'b10000;
      3'b000:  return 5'b01000;
      3'b101:  return 5'b00100;
      3'b001:  return 5'b00010;
      3'b010:  return 5'b00001;
      default: return 5'b00000;
    endcase
  endfunction

  always @(posedge clk) begin
    started <= 1'b1;
    if (!reset) begin
      m_phase <= 0; m_ptr <= 0; m_own <= 0; m_we <= 0;
      m_addr <= '0; m_wd <= '0; m_rdata <= '0; m_irq <= 0;
    end else begin
      m_irq <= counterIrq || (m_irq && !(m_phase == 1 && m_we
               && m_addr == 2'd3 && m_wd[0]));
      if (m_phase == 0) begin
        pick = -1;
        for (int k = 0; k < N; k++)
          if (pick < 0 && req[(m_ptr + k) % N]) pick = (m_ptr + k) % N;
        if (pick >= 0) begin
          m_own   <= pick;
          m_we    <= we[pick];
          m_addr  <= addr[2*pick +: 2];
          m_wd    <= wdata[32*pick +: 32];
          m_phase <= 1;
        end
      end else if (m_phase == 1) begin
        m_rdata <= m_we ? 32'h0 : reg_read(m_addr, m_irq);
        m_ptr   <= (m_own + 1) % N;
        m_phase <= 2;
      end else begin
        m_phase <= 0;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (started) begin
      chk("gnt", 32'(gnt),
          (m_phase == 1) ? 32'(1 << m_own) : 32'h0);
      chk("rvalid", 32'(rvalid),
          (m_phase == 2) ? 32'(1 << m_own) : 32'h0);
      chk("strobes", 32'({counterWe, counterRe, counterConfigWe,
          counterConfigRe, counterStatusRe}),
          32'(exp_stb(m_phase, m_we, m_addr)));
      chk("irq", 32'(irq), 32'(m_irq));
      chk("counterIn", counterIn, m_wd);
      chk("en_dir", 32'({counterDirIn, counterEnIn}), 32'(m_wd[1:0]));
      if (rvalid != 0) chk("rdata", rdata, m_rdata);
    end
  end

  logic [4:0]  g_stb;
  logic [31:0] g_cin;
  logic [1:0]  g_ed;
  logic [31:0] rd;

  // One register access by requester i; returns read data at rvalid
  task automatic access(input int i, input bit w, input logic [1:0] a,
                        input logic [31:0] d, input bit irq_at_gnt,
                        output logic [31:0] r);
    bit ok;
    r = '0;
    @(negedge clk);
    req[i] = 1'b1;
    we[i] = w;
    addr[2*i +: 2] = a;
    wdata[32*i +: 32] = d;
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      if (gnt[i]) ok = 1'b1;
    end
    if (!ok) chk("gnt_timeout", 32'd0, 32'd1);
    g_stb = {counterWe, counterRe, counterConfigWe,
             counterConfigRe, counterStatusRe};
    g_cin = counterIn;
    g_ed  = {counterDirIn, counterEnIn};
    req[i] = 1'b0;
    if (irq_at_gnt) counterIrq = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      counterIrq = 1'b0;
      if (rvalid[i]) ok = 1'b1;
    end
    if (!ok) chk("rvalid_timeout", 32'd0, 32'd1);
    r = rdata;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    req = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  int gq[$];
  int gt[$];
  int cyc;

  initial begin
    reset = 1'b0;
    req = '0; we = '0; addr = '0; wdata = '0;
    counterIrq = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_cin", counterIn, 32'h0);
    reset = 1'b1;
    cyc = 0;
    repeat (10) begin
      @(negedge clk);
      if (gnt != 0 || counterWe || counterRe) cyc++;
    end
    chk("idle_quiet", 32'(cyc), 32'd0);

    access(0, 1'b1, 2'd0, 32'h0000_1234, 1'b0, rd);
    chk("w0_strobe", 32'(g_stb), 32'h10);
    chk("w0_cin", g_cin, 32'h1234);
    access(0, 1'b0, 2'd0, 32'h0, 1'b0, rd);
    chk("r0_data", rd, 32'h1234);

    do_reset();
    @(negedge clk);
    req = 2'b11; we = '0; addr = '0;
    cyc = 0;
    while (gq.size() < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (gnt != 0) begin
        gq.push_back(gnt[1] ? 1 : 0);
        gt.push_back(cyc);
      end
    end
    req = '0;
    if (gq.size() < 4) chk("rr_timeout", 32'(gq.size()), 32'd4);
    else begin
      chk("rr_order", {gq[0][7:0], gq[1][7:0], gq[2][7:0], gq[3][7:0]},
          32'h00010001);
      chk("rr_gap1", 32'(gt[1] - gt[0]), 32'd3);
      chk("rr_gap3", 32'(gt[3] - gt[2]), 32'd3);
    end
    repeat (3) @(negedge clk);

    access(1, 1'b1, 2'd1, 32'h3, 1'b0, rd);
    chk("w1_strobe", 32'(g_stb), 32'h04);
    chk("w1_en_dir", 32'(g_ed), 32'h3);
    access(0, 1'b0, 2'd1, 32'h0, 1'b0, rd);
    chk("r1_data", rd, 32'h3);
    access(0, 1'b1, 2'd0, 32'd999, 1'b0, rd);
    access(1, 1'b0, 2'd2, 32'h0, 1'b0, rd);
    chk("r2_999", rd, 32'd1);
    chk("r2_strobe", 32'(g_stb), 32'h01);
    access(0, 1'b1, 2'd0, 32'd1000, 1'b0, rd);
    access(1, 1'b0, 2'd2, 32'h0, 1'b0, rd);
    chk("r2_1000", rd, 32'd0);
    access(0, 1'b1, 2'd2, 32'hFFFF_FFFF, 1'b0, rd);
    chk("w2_nostrobe", 32'(g_stb), 32'h0);

    @(negedge clk);
    counterIrq = 1'b1;
    @(negedge clk);
    counterIrq = 1'b0;
    chk("irq_set", 32'(irq), 32'd1);
    repeat (3) @(negedge clk);
    chk("irq_sticky", 32'(irq), 32'd1);
    access(1, 1'b0, 2'd3, 32'h0, 1'b0, rd);
    chk("r3_data", rd, 32'd1);
    access(0, 1'b1, 2'd3, 32'h0, 1'b0, rd);
    chk("w3_zero_keep", 32'(irq), 32'd1);
    access(0, 1'b1, 2'd3, 32'h1, 1'b0, rd);
    chk("w3_clear", 32'(irq), 32'd0);
    access(1, 1'b1, 2'd3, 32'h1, 1'b1, rd);
    chk("w3_set_wins", 32'(irq), 32'd1);

    access(0, 1'b0, 2'd0, 32'h0, 1'b0, rd);
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; addr[1:0] = 2'd0;
    wdata[31:0] = 32'h55;
    cyc = 0;
    while (!gnt[0] && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("abort_gnt", 32'(gnt[0]), 32'd1);
    reset = 1'b0;
    req = '0;
    @(negedge clk);
    chk("abort_rvalid", 32'(rvalid), 32'h0);
    chk("abort_strobe", 32'({counterWe, counterRe, counterConfigWe,
        counterConfigRe, counterStatusRe}), 32'h0);
    reset = 1'b1;
    req = 2'b11; we = '0; addr = '0;
    cyc = 0;
    while (gnt == 0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("post_rst_first", 32'(gnt), 32'h1);
    req = '0;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", n_err);
    $fatal(1, "watchdog");
  end

endmodule
